gnrc_edge_event_arb: RTL and testbench

GNRC_EDGE_EVENT_ARB -- requirements
Module: gnrc_edge_event_arb

---
 rtl/gnrc_edge_event_arb.sv | 106 ++++++++++
 tb/tb_gnrc_edge_event_arb.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gnrc_edge_event_arb.sv
// Edge detector with per-channel saturating event counters and a round-robin record arbiter.
// Edge counted at clock t emits at t+1 on an idle output; the record holds while valid && !ready.
module gnrc_edge_event_arb #(
  parameter int NCH   = 4,
  parameter int CNT_W = 4,
  localparam int IDW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [NCH-1:0]   d_i,
  input  logic [NCH-1:0]   rise_en_i,
  input  logic [NCH-1:0]   fall_en_i,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic [IDW-1:0]   evt_id_o,
  output logic             evt_rise_o,
  output logic [CNT_W-1:0] evt_cnt_o,
  output logic [NCH-1:0]   ovf_o,
  input  logic             ovf_clr_i
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NCH-1:0]   d_r;
  logic [NCH-1:0]   rise;
  logic [NCH-1:0]   fall;
  logic [NCH-1:0]   qual;
  logic [NCH-1:0]   gsel;
  logic [NCH-1:0]   sat_hit;
  logic [CNT_W-1:0] cnt [NCH];
  logic [NCH-1:0]   last;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   gnt;
  logic             gnt_vld;
  logic             load;
  logic             take;

  assign rise = d_i & ~d_r;
  assign fall = ~d_i & d_r;
  assign qual = {NCH{en_i}} & ((rise & rise_en_i) | (fall & fall_en_i));
  assign load = ~evt_valid_o | evt_ready_i;
  assign take = load & gnt_vld;

  // Scan from the farthest offset down so the nearest non-empty channel at/after ptr wins.
  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_vld = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NCH;
      if (cnt[idx] != '0) begin
        gnt     = IDW'(idx);
        gnt_vld = 1'b1;
      end
    end
  end

  always_comb begin
    gsel    = '0;
    sat_hit = '0;
    for (int c = 0; c < NCH; c++) begin
      gsel[c]    = take && (int'(gnt) == c);
      sat_hit[c] = qual[c] && !gsel[c] && (cnt[c] == CNT_MAX);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      d_r         <= d_i;
      last        <= '0;
      ptr         <= '0;
      evt_valid_o <= 1'b0;
      evt_id_o    <= '0;
      evt_cnt_o   <= '0;
      evt_rise_o  <= 1'b0;
      ovf_o       <= '0;
      for (int c = 0; c < NCH; c++) cnt[c] <= '0;
    end else begin
      d_r   <= d_i;
      ovf_o <= (ovf_clr_i ? '0 : ovf_o) | sat_hit;
      for (int c = 0; c < NCH; c++) begin
        // A granted channel restarts from the same-cycle event, which is not in the record.
        if (gsel[c])
          cnt[c] <= CNT_W'(qual[c]);
        else if (qual[c] && cnt[c] != CNT_MAX)
          cnt[c] <= cnt[c] + 1'b1;
        if (qual[c])
          last[c] <= rise[c];
      end
      if (load) begin
        if (gnt_vld) begin
          evt_valid_o <= 1'b1;
          evt_id_o    <= gnt;
          evt_cnt_o   <= cnt[gnt];
          evt_rise_o  <= last[gnt];
          ptr         <= IDW'((int'(gnt) + 1) % NCH);
        end else begin
          evt_valid_o <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_gnrc_edge_event_arb.sv
// Two instances (CNT_W=4 and CNT_W=2) share stimulus; each is checked every cycle against a
// queue-free counting model, with literal expectations for the directed scenarios.
module tb_gnrc_edge_event_arb;

  localparam int NCH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] d;
  logic [3:0] re;
  logic [3:0] fe;
  logic       rdy;
  logic       clr;

  logic       v_a, v_b;
  logic [1:0] id_a, id_b;
  logic       r_a, r_b;
  logic [3:0] c_a;
  logic [1:0] c_b;
  logic [3:0] ovf_a, ovf_b;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gnrc_edge_event_arb #(.NCH(4), .CNT_W(4)) dut_a (
    .clk_i(clk), .rst_i(rst), .en_i(en), .d_i(d), .rise_en_i(re), .fall_en_i(fe),
    .evt_valid_o(v_a), .evt_ready_i(rdy), .evt_id_o(id_a), .evt_rise_o(r_a),
    .evt_cnt_o(c_a), .ovf_o(ovf_a), .ovf_clr_i(clr)
  );

  gnrc_edge_event_arb #(.NCH(4), .CNT_W(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .en_i(en), .d_i(d), .rise_en_i(re), .fall_en_i(fe),
    .evt_valid_o(v_b), .evt_ready_i(rdy), .evt_id_o(id_b), .evt_rise_o(r_b),
    .evt_cnt_o(c_b), .ovf_o(ovf_b), .ovf_clr_i(clr)
  );

  // Reference model: index 0 tracks dut_a, index 1 tracks dut_b.
  int m_maxc [2] = '{15, 3};
  int m_cnt  [2][NCH];
  bit m_last [2][NCH];
  bit m_ovf  [2][NCH];
  int m_ptr  [2];
  bit m_v    [2];
  int m_id   [2];
  int m_c    [2];
  bit m_r    [2];
  bit m_dr   [NCH];

  task automatic model_step();
    bit q[NCH];
    bit rz[NCH];
    bit fl;
    bit load;
    int g;
    int c;
    int rec_cnt;
    bit rec_rise;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        for (int j = 0; j < NCH; j++) begin
          m_cnt[k][j] = 0; m_last[k][j] = 0; m_ovf[k][j] = 0;
        end
        m_ptr[k] = 0; m_v[k] = 0; m_id[k] = 0; m_c[k] = 0; m_r[k] = 0;
      end
    end else begin
      for (int j = 0; j < NCH; j++) begin
        rz[j] = d[j] && !m_dr[j];
        fl    = !d[j] && m_dr[j];
        q[j]  = en && ((rz[j] && re[j]) || (fl && fe[j]));
      end
      for (int k = 0; k < 2; k++) begin
        load = !m_v[k] || rdy;
        g = -1;
        rec_cnt = 0;
        rec_rise = 0;
        if (load) begin
          for (int i = 0; i < NCH; i++) begin
            c = (m_ptr[k] + i) % NCH;
            if (g < 0 && m_cnt[k][c] > 0) g = c;
          end
        end
        if (g >= 0) begin
          rec_cnt  = m_cnt[k][g];
          rec_rise = m_last[k][g];
        end
        if (clr) for (int j = 0; j < NCH; j++) m_ovf[k][j] = 0;
        for (int j = 0; j < NCH; j++) begin
          if (j == g) m_cnt[k][j] = q[j] ? 1 : 0;
          else if (q[j]) begin
            if (m_cnt[k][j] == m_maxc[k]) m_ovf[k][j] = 1;
            else m_cnt[k][j] = m_cnt[k][j] + 1;
          end
          if (q[j]) m_last[k][j] = rz[j];
        end
        if (load) begin
          if (g >= 0) begin
            m_v[k] = 1; m_id[k] = g; m_c[k] = rec_cnt; m_r[k] = rec_rise;
            m_ptr[k] = (g + 1) % NCH;
          end else begin
            m_v[k] = 0;
          end
        end
      end
    end
    for (int j = 0; j < NCH; j++) m_dr[j] = d[j];
  endtask

  function automatic logic [31:0] ovf_pack(input int k);
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < NCH; j++) r[j] = m_ovf[k][j];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("a_valid", 32'(v_a), 32'(m_v[0]));
    if (m_v[0]) begin
      chk("a_id", 32'(id_a), 32'(m_id[0]));
      chk("a_cnt", 32'(c_a), 32'(m_c[0]));
      chk("a_rise", 32'(r_a), 32'(m_r[0]));
    end
    chk("a_ovf", 32'(ovf_a), ovf_pack(0));
    chk("b_valid", 32'(v_b), 32'(m_v[1]));
    if (m_v[1]) begin
      chk("b_id", 32'(id_b), 32'(m_id[1]));
      chk("b_cnt", 32'(c_b), 32'(m_c[1]));
      chk("b_rise", 32'(r_b), 32'(m_r[1]));
    end
    chk("b_ovf", 32'(ovf_b), ovf_pack(1));
  endtask

  // Apply one cycle of inputs, advance the model, then compare after the edge.
  task automatic cyc(input logic [3:0] dd, input logic [3:0] re_, input logic [3:0] fe_,
                     input logic en_, input logic rdy_, input logic rst_, input logic clr_);
    d = dd; re = re_; fe = fe_; en = en_; rdy = rdy_; rst = rst_; clr = clr_;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    d = '0; re = '0; fe = '0; en = 1'b1; rdy = 1'b1; rst = 1'b1; clr = 1'b0;
    @(negedge clk);

    // Reset state, then a single rise on channel 2.
    cyc(4'h0, 4'hF, 4'h0, 1, 1, 1, 0);
    cyc(4'h0, 4'hF, 4'h0, 1, 1, 1, 0);
    chk("rst_valid", 32'(v_a), 0);
    chk("rst_ovf", 32'(ovf_a), 0);
    cyc(4'h0, 4'hF, 4'h0, 1, 1, 0, 0);
    cyc(4'h4, 4'hF, 4'h0, 1, 1, 0, 0);
    cyc(4'h4, 4'hF, 4'h0, 1, 1, 0, 0);
    chk("t33_valid", 32'(v_a), 1);
    chk("t33_id", 32'(id_a), 2);
    chk("t33_cnt", 32'(c_a), 1);
    chk("t33_rise", 32'(r_a), 1);
    cyc(4'h4, 4'hF, 4'h0, 1, 1, 0, 0);
    chk("t33_idle", 32'(v_a), 0);

    // Folding: f r f r f on channel 0 under backpressure.
    cyc(4'h1, 4'hF, 4'hF, 1, 0, 1, 0);
    cyc(4'h0, 4'hF, 4'hF, 1, 0, 0, 0);
    cyc(4'h1, 4'hF, 4'hF, 1, 0, 0, 0);
    cyc(4'h0, 4'hF, 4'hF, 1, 0, 0, 0);
    cyc(4'h1, 4'hF, 4'hF, 1, 0, 0, 0);
    cyc(4'h0, 4'hF, 4'hF, 1, 0, 0, 0);
    chk("t34_first_cnt", 32'(c_a), 1);
    chk("t34_first_rise", 32'(r_a), 0);
    cyc(4'h0, 4'hF, 4'hF, 1, 1, 0, 0);
    chk("t34_second_id", 32'(id_a), 0);
    chk("t34_second_cnt", 32'(c_a), 4);
    chk("t34_second_rise", 32'(r_a), 0);
    chk("t34_b_sat_cnt", 32'(c_b), 3);

    // Simultaneous edges on 0,1,3 drain in round-robin order, then ptr wraps.
    cyc(4'h0, 4'hF, 4'hF, 1, 1, 1, 0);
    cyc(4'hB, 4'hF, 4'hF, 1, 1, 0, 0);
    cyc(4'hB, 4'hF, 4'hF, 1, 1, 0, 0);
    chk("t35_g0", 32'(id_a), 0);
    cyc(4'hB, 4'hF, 4'hF, 1, 1, 0, 0);
    chk("t35_g1", 32'(id_a), 1);
    cyc(4'hB, 4'hF, 4'hF, 1, 1, 0, 0);
    chk("t35_g3", 32'(id_a), 3);
    cyc(4'hA, 4'hF, 4'hF, 1, 1, 0, 0);
    chk("t35_gap", 32'(v_a), 0);
    cyc(4'hA, 4'hF, 4'hF, 1, 1, 0, 0);
    chk("t35_wrap_v", 32'(v_a), 1);
    chk("t35_wrap_id", 32'(id_a), 0);

    // Saturation and sticky overflow on the narrow instance.
    cyc(4'h0, 4'hF, 4'h0, 1, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(4'h2, 4'hF, 4'h0, 1, 0, 0, 0);
      if (i < 4) cyc(4'h0, 4'hF, 4'h0, 1, 0, 0, 0);
    end
    chk("t36_ovf_set", 32'(ovf_b[1]), 1);
    chk("t36_a_no_ovf", 32'(ovf_a), 0);
    cyc(4'h0, 4'hF, 4'h0, 1, 0, 0, 0);
    cyc(4'h2, 4'hF, 4'h0, 1, 0, 0, 1);
    chk("t36_set_wins", 32'(ovf_b[1]), 1);
    cyc(4'h2, 4'hF, 4'h0, 1, 0, 0, 1);
    chk("t36_cleared", 32'(ovf_b), 0);

    // High levels through reset release, then fall-only qualification.
    cyc(4'hF, 4'hF, 4'hF, 1, 1, 1, 0);
    cyc(4'hF, 4'hF, 4'hF, 1, 1, 1, 0);
    cyc(4'hF, 4'hF, 4'hF, 1, 1, 0, 0);
    cyc(4'hF, 4'hF, 4'hF, 1, 1, 0, 0);
    chk("t37_no_spur", 32'(v_a), 0);
    cyc(4'hB, 4'h0, 4'hF, 1, 1, 0, 0);
    cyc(4'hB, 4'h0, 4'hF, 1, 1, 0, 0);
    chk("t37_fall_id", 32'(id_a), 2);
    chk("t37_fall_rise", 32'(r_a), 0);
    cyc(4'hF, 4'h0, 4'hF, 1, 1, 0, 0);
    cyc(4'hF, 4'h0, 4'hF, 1, 1, 0, 0);
    chk("t37_rise_ignored", 32'(v_a), 0);

    // Reset mid-transfer drops the held record.
    cyc(4'hE, 4'h0, 4'hF, 1, 0, 0, 0);
    cyc(4'hE, 4'h0, 4'hF, 1, 0, 0, 0);
    chk("t38_held", 32'(v_a), 1);
    cyc(4'hE, 4'h0, 4'hF, 1, 0, 1, 0);
    chk("t38_drop", 32'(v_a), 0);
    chk("t38_ovf", 32'(ovf_b), 0);
    cyc(4'hE, 4'h0, 4'hF, 1, 1, 0, 0);
    cyc(4'hE, 4'h0, 4'hF, 1, 1, 0, 0);
    chk("t38_quiet", 32'(v_a), 0);

    // Randomized traffic with backpressure phases, enable churn, clears and resets.
    begin
      logic [3:0] rd, rre, rfe;
      logic ren, rrdy, rrst, rclr;
      rd = 4'hE; rre = 4'hF; rfe = 4'hF;
      for (int i = 0; i < 3000; i++) begin
        rd = rd ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15));
        if ($urandom_range(0, 19) == 0) rre = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 19) == 0) rfe = 4'($urandom_range(0, 15));
        ren  = ($urandom_range(0, 9) != 0);
        rrdy = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
        rrst = ($urandom_range(0, 299) == 0);
        rclr = ($urandom_range(0, 15) == 0);
        cyc(rd, rre, rfe, ren, rrdy, rrst, rclr);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
